// File: rtl/rom_read_arbiter_if.sv
// Requester and ROM-side signal bundle for rom_read_arbiter.
// slave = arbiter side, master = requesters plus the ROM model.
interface rom_read_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  req0;
  logic                  req1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [1:0]            len0;
  logic [1:0]            len1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic                  rlast0;
  logic                  rlast1;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] rom_address;
  logic                  rom_chip_select;
  logic [DATA_WIDTH-1:0] rom_data_in;

  modport slave (
    input  req0, req1, addr0, addr1, len0, len1, rom_data_in,
    output gnt0, gnt1, rvalid0, rvalid1, rlast0, rlast1, rdata,
           rom_address, rom_chip_select
  );

  modport master (
    output req0, req1, addr0, addr1, len0, len1, rom_data_in,
    input  gnt0, gnt1, rvalid0, rvalid1, rlast0, rlast1, rdata,
           rom_address, rom_chip_select
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Two-port word/burst read arbiter for the 32-word instruction ROM.
// Define ROM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to port 0.
//
// state | meaning
// IDLE  | no ROM access, requests sampled
// READ  | ROM access in progress, one beat per cycle
module rom_read_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  rom_read_arbiter_if.slave bus
);

  typedef enum logic {IDLE, READ} state_t;

  state_t                state;
  state_t                state_next;
  logic                  owner;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [1:0]            beat;
  logic [1:0]            blen;
  logic                  last_beat;
  logic                  win_valid;
  logic                  win_port;
  logic                  gnt0_q, gnt1_q;
  logic                  rvalid0_q, rvalid1_q;
  logic                  rlast0_q, rlast1_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  cs;
  logic [ADDR_WIDTH-1:0] rom_addr;

  assign win_valid = bus.req0 | bus.req1;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  // rr_ptr names the port that wins the next tie
  logic rr_ptr;
  assign win_port = (bus.req0 & bus.req1) ? rr_ptr : bus.req1;
`else
  assign win_port = ~bus.req0;
`endif

  assign last_beat = (beat == blen);

  always_comb begin
    state_next = state;
    cs         = 1'b0;
    rom_addr   = '0;
    case (state)
      IDLE: begin
        if (win_valid) state_next = READ;
      end
      READ: begin
        cs       = 1'b1;
        rom_addr = cur_addr;
        if (last_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      cur_addr  <= '0;
      beat      <= '0;
      blen      <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rlast0_q  <= 1'b0;
      rlast1_q  <= 1'b0;
      rdata_q   <= '0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rlast0_q  <= 1'b0;
      rlast1_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            owner    <= win_port;
            cur_addr <= win_port ? bus.addr1 : bus.addr0;
            blen     <= win_port ? bus.len1 : bus.len0;
            beat     <= '0;
            gnt0_q   <= ~win_port;
            gnt1_q   <= win_port;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            rr_ptr   <= ~win_port;
`endif
          end
        end
        READ: begin
          rdata_q   <= bus.rom_data_in;
          rvalid0_q <= ~owner;
          rvalid1_q <= owner;
          rlast0_q  <= ~owner & last_beat;
          rlast1_q  <= owner & last_beat;
          cur_addr  <= cur_addr + ADDR_WIDTH'(1);
          beat      <= beat + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt0            = gnt0_q;
  assign bus.gnt1            = gnt1_q;
  assign bus.rvalid0         = rvalid0_q;
  assign bus.rvalid1         = rvalid1_q;
  assign bus.rlast0          = rlast0_q;
  assign bus.rlast1          = rlast1_q;
  assign bus.rdata           = rdata_q;
  assign bus.rom_address     = rom_addr;
  assign bus.rom_chip_select = cs;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: per-cycle vector table plus tie, reset and busy sequences.
module tb_rom_read_arbiter;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rom_read_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  rom_read_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] romw(input logic [4:0] a);
    if (a == 5'd7) return 32'hDEADBEEF;
    return 32'h5A00_0000 | (32'(a) << 12) | 32'(a);
  endfunction

  // ROM model: floating output replaced by a sentinel so stray sampling shows up
  assign bus.rom_data_in = bus.rom_chip_select ? romw(bus.rom_address) : 32'hBAD0_BAD0;

  typedef struct {
    logic        r0, r1;
    logic [4:0]  a0, a1;
    logic [1:0]  l0, l1;
    logic [6:0]  flags;   // {gnt0,gnt1,rvalid0,rvalid1,rlast0,rlast1,chip_select}
    logic [4:0]  ra;
    logic        chk_rd;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic r0, input logic r1, input logic [4:0] a0,
                              input logic [4:0] a1, input logic [1:0] l0, input logic [1:0] l1,
                              input logic [6:0] flags, input logic [4:0] ra,
                              input logic chk_rd, input logic [31:0] rd);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1; v.l0 = l0; v.l1 = l1;
    v.flags = flags; v.ra = ra; v.chk_rd = chk_rd; v.rd = rd;
    return v;
  endfunction

  function automatic logic [6:0] flags_now();
    return {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.rlast0, bus.rlast1,
            bus.rom_chip_select};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic r1, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [1:0] l0, input logic [1:0] l1);
    bus.req0 = r0; bus.req1 = r1; bus.addr0 = a0; bus.addr1 = a1; bus.len0 = l0; bus.len1 = l1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_g;
    int rl_cyc, g_cyc, k0, k1;

    // single read, 4-beat burst, wrap-around burst
    tbl[0]  = mk(0, 0, 0,  0, 0, 0, 7'b0000000, 0,  1, 32'h0);
    tbl[1]  = mk(1, 0, 7,  0, 0, 0, 7'b0000000, 0,  1, 32'h0);
    tbl[2]  = mk(0, 0, 0,  0, 0, 0, 7'b1000001, 7,  0, 32'h0);
    tbl[3]  = mk(0, 1, 0,  4, 0, 3, 7'b0010100, 0,  1, 32'hDEADBEEF);
    tbl[4]  = mk(0, 0, 0,  0, 0, 0, 7'b0100001, 4,  0, 32'h0);
    tbl[5]  = mk(0, 0, 0,  0, 0, 0, 7'b0001001, 5,  1, romw(4));
    tbl[6]  = mk(0, 0, 0,  0, 0, 0, 7'b0001001, 6,  1, romw(5));
    tbl[7]  = mk(0, 0, 0,  0, 0, 0, 7'b0001001, 7,  1, romw(6));
    tbl[8]  = mk(1, 0, 30, 0, 3, 0, 7'b0001010, 0,  1, romw(7));
    tbl[9]  = mk(0, 0, 0,  0, 0, 0, 7'b1000001, 30, 0, 32'h0);
    tbl[10] = mk(0, 0, 0,  0, 0, 0, 7'b0010001, 31, 1, romw(30));
    tbl[11] = mk(0, 0, 0,  0, 0, 0, 7'b0010001, 0,  1, romw(31));
    tbl[12] = mk(0, 0, 0,  0, 0, 0, 7'b0010001, 1,  1, romw(0));
    tbl[13] = mk(0, 0, 0,  0, 0, 0, 7'b0010100, 0,  1, romw(1));
    tbl[14] = mk(0, 0, 0,  0, 0, 0, 7'b0000000, 0,  0, 32'h0);

    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].r0, tbl[i].r1, tbl[i].a0, tbl[i].a1, tbl[i].l0, tbl[i].l1);
      @(negedge clk);
      check($sformatf("vec%0d_flags", i), 32'(flags_now()), 32'(tbl[i].flags));
      check($sformatf("vec%0d_rom_address", i), 32'(bus.rom_address), 32'(tbl[i].ra));
      if (tbl[i].chk_rd) check($sformatf("vec%0d_rdata", i), bus.rdata, tbl[i].rd);
      tick();
    end

    // both ports requesting continuously, single words
    do_reset();
    drive(1, 1, 2, 3, 0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rvalid_exclusive", 32'(bus.rvalid0 & bus.rvalid1), 32'h0);
      if (i % 2 == 1) exp_g = (RR && (((i - 1) / 2) % 2 == 1)) ? 2'b01 : 2'b10;
      else            exp_g = 2'b00;
      check($sformatf("tie_gnt_cyc%0d", i), 32'({bus.gnt0, bus.gnt1}), 32'(exp_g));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // reset in the second READ cycle of a 4-beat burst
    do_reset();
    drive(1, 0, 10, 0, 3, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_burst_gnt0", 32'(flags_now()), 32'(7'b1000001));
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rst_burst_addr_beat1", 32'(bus.rom_address), 32'd11);
    tick();
    reset = 1'b0;
    drive(0, 1, 0, 5, 0, 0);
    @(negedge clk);
    check("after_rst_flags", 32'(flags_now()), 32'h0);
    check("after_rst_rom_address", 32'(bus.rom_address), 32'h0);
    check("after_rst_rdata", bus.rdata, 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("post_rst_gnt1", 32'(flags_now()), 32'(7'b0100001));
    check("post_rst_rom_address", 32'(bus.rom_address), 32'd5);
    tick();
    @(negedge clk);
    check("post_rst_rvalid1", 32'(flags_now()), 32'(7'b0001010));
    check("post_rst_rdata", bus.rdata, romw(5));
    tick();

    // port 1 requests while port 0 runs a 3-beat burst
    drive(1, 0, 20, 0, 2, 0);
    tick();
    drive(0, 1, 0, 9, 0, 0);
    rl_cyc = -1; g_cyc = -1; k0 = 0; k1 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("busy_rvalid_exclusive", 32'(bus.rvalid0 & bus.rvalid1), 32'h0);
      if (bus.rlast0 && rl_cyc < 0) rl_cyc = i;
      if (bus.gnt1 && g_cyc < 0) g_cyc = i;
      if (bus.rvalid0) begin
        check($sformatf("busy_p0_beat%0d", k0), bus.rdata, romw(5'(20 + k0)));
        k0++;
      end
      if (bus.rvalid1) begin
        check("busy_p1_rdata", bus.rdata, romw(9));
        k1++;
      end
      tick();
      if (g_cyc >= 0) bus.req1 = 1'b0;
    end
    check("busy_rlast0_cycle", 32'(rl_cyc), 32'd3);
    check("busy_gnt1_cycle", 32'(g_cyc), 32'd4);
    check("busy_p0_beats", 32'(k0), 32'd3);
    check("busy_p1_beats", 32'(k1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
